// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_pkg
// Brief    : Shared types and constants for the 5-stage, 8-register pipeline.
// Revision : 1.0
// ============================================================================
package cpu_pkg;

   localparam int REG_BITS = 3;

   // Zeroed control word loaded into a pipeline register to form a bubble
   localparam logic [7:0] NOP_CTRL = 8'h00;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      HALTED   = 2'd2
   } hz_state_t;

endpackage
`default_nettype wire

// File: rtl/hazard_controller_sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter
// Brief    : Up-counter with synchronous clear that holds at all-ones.
// Revision : 1.0
// ============================================================================
module sat_counter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear_i,
   input  logic             inc_i,
   output logic [WIDTH-1:0] count_o
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (inc_i && !(&count_q)) begin
         count_d = count_q + WIDTH'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/hazard_controller.sv
`default_nettype none
// ============================================================================
// Module   : hazard_controller
// Brief    : Stall / bubble / flush sequencing with memory-wait watchdog.
// Revision : 1.0
// ============================================================================
module hazard_controller #(
   parameter int REG_BITS    = cpu_pkg::REG_BITS,
   parameter int MEM_TIMEOUT = 64,
   parameter int CNT_W       = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [REG_BITS-1:0] ID_Rs,
   input  logic [REG_BITS-1:0] ID_Rd,
   input  logic                ID_UsesRs,
   input  logic                ID_UsesRd,
   input  logic [REG_BITS-1:0] EX_Rd,
   input  logic                EX_MemRead,
   input  logic                EX_BranchTaken,
   input  logic                MEM_Req,
   input  logic                MEM_Ack,
   output logic                PC_Write,
   output logic                IFID_Write,
   output logic                IFID_Flush,
   output logic                IDEX_Write,
   output logic                IDEX_Bubble,
   output logic                EXMEM_Write,
   output logic                MEMWB_Bubble,
   output logic                Timeout,
   output logic [CNT_W-1:0]    StallCount
);

   import cpu_pkg::*;

   // One spare count so the counter never wraps on the tripping cycle
   localparam int                WAIT_W    = $clog2(MEM_TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

   hz_state_t         state_q;
   hz_state_t         state_d;
   logic [WAIT_W-1:0] wait_cnt;
   logic              halted;
   logic              freeze;
   logic              loaduse;
   logic              rs_hit;
   logic              rd_hit;

   assign halted  = (state_q == HALTED);
   assign freeze  = MEM_Req & ~MEM_Ack & ~halted;
   assign rs_hit  = ID_UsesRs & (EX_Rd == ID_Rs);
   assign rd_hit  = ID_UsesRd & (EX_Rd == ID_Rd);
   assign loaduse = EX_MemRead & (EX_Rd != '0) & (rs_hit | rd_hit);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= RUN;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         RUN: begin
            if (freeze) state_d = MEM_WAIT;
         end
         MEM_WAIT: begin
            if (freeze && (wait_cnt == WAIT_LAST)) begin
               state_d = HALTED;
            end else if (!freeze) begin
               state_d = RUN;
            end
         end
         HALTED:  state_d = HALTED;
         default: state_d = RUN;
      endcase
   end

   // Priority: halted > memory freeze > taken branch > load-use > defaults
   always_comb begin
      PC_Write     = 1'b1;
      IFID_Write   = 1'b1;
      IFID_Flush   = 1'b0;
      IDEX_Write   = 1'b1;
      IDEX_Bubble  = 1'b0;
      EXMEM_Write  = 1'b1;
      MEMWB_Bubble = 1'b0;
      Timeout      = 1'b0;
      if (reset) begin
         Timeout = 1'b0;
      end else if (halted) begin
         PC_Write     = 1'b0;
         IFID_Write   = 1'b0;
         IDEX_Write   = 1'b0;
         EXMEM_Write  = 1'b0;
         MEMWB_Bubble = 1'b1;
         Timeout      = 1'b1;
      end else if (freeze) begin
         PC_Write     = 1'b0;
         IFID_Write   = 1'b0;
         IDEX_Write   = 1'b0;
         EXMEM_Write  = 1'b0;
         MEMWB_Bubble = 1'b1;
      end else if (EX_BranchTaken) begin
         IFID_Flush  = 1'b1;
         IDEX_Bubble = 1'b1;
      end else if (loaduse) begin
         PC_Write    = 1'b0;
         IFID_Write  = 1'b0;
         IDEX_Bubble = 1'b1;
      end
   end

   sat_counter #(
      .WIDTH (WAIT_W)
   ) u_wait_cnt (
      .clk     (clk),
      .reset   (reset),
      .clear_i (~freeze),
      .inc_i   (freeze),
      .count_o (wait_cnt)
   );

   sat_counter #(
      .WIDTH (CNT_W)
   ) u_stall_cnt (
      .clk     (clk),
      .reset   (reset),
      .clear_i (1'b0),
      .inc_i   (~PC_Write),
      .count_o (StallCount)
   );

endmodule
`default_nettype wire

// File: tb/tb_hazard_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_controller
// Brief    : Directed vector table plus multi-cycle wait/watchdog sequences.
// Revision : 1.0
// ============================================================================
module tb_hazard_controller;

   logic       clk = 1'b0;
   logic       reset;
   logic [2:0] ID_Rs, ID_Rd, EX_Rd;
   logic       ID_UsesRs, ID_UsesRd, EX_MemRead, EX_BranchTaken, MEM_Req, MEM_Ack;

   logic        PC_Write, IFID_Write, IFID_Flush, IDEX_Write, IDEX_Bubble;
   logic        EXMEM_Write, MEMWB_Bubble, Timeout;
   logic [15:0] StallCount;

   logic       s_PC_Write, s_IFID_Write, s_IFID_Flush, s_IDEX_Write, s_IDEX_Bubble;
   logic       s_EXMEM_Write, s_MEMWB_Bubble, s_Timeout;
   logic [3:0] s_StallCount;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   hazard_controller #(.REG_BITS(3), .MEM_TIMEOUT(4), .CNT_W(16)) dut (
      .clk(clk), .reset(reset),
      .ID_Rs(ID_Rs), .ID_Rd(ID_Rd), .ID_UsesRs(ID_UsesRs), .ID_UsesRd(ID_UsesRd),
      .EX_Rd(EX_Rd), .EX_MemRead(EX_MemRead), .EX_BranchTaken(EX_BranchTaken),
      .MEM_Req(MEM_Req), .MEM_Ack(MEM_Ack),
      .PC_Write(PC_Write), .IFID_Write(IFID_Write), .IFID_Flush(IFID_Flush),
      .IDEX_Write(IDEX_Write), .IDEX_Bubble(IDEX_Bubble), .EXMEM_Write(EXMEM_Write),
      .MEMWB_Bubble(MEMWB_Bubble), .Timeout(Timeout), .StallCount(StallCount)
   );

   hazard_controller #(.REG_BITS(3), .MEM_TIMEOUT(64), .CNT_W(4)) dut_sat (
      .clk(clk), .reset(reset),
      .ID_Rs(ID_Rs), .ID_Rd(ID_Rd), .ID_UsesRs(ID_UsesRs), .ID_UsesRd(ID_UsesRd),
      .EX_Rd(EX_Rd), .EX_MemRead(EX_MemRead), .EX_BranchTaken(EX_BranchTaken),
      .MEM_Req(MEM_Req), .MEM_Ack(MEM_Ack),
      .PC_Write(s_PC_Write), .IFID_Write(s_IFID_Write), .IFID_Flush(s_IFID_Flush),
      .IDEX_Write(s_IDEX_Write), .IDEX_Bubble(s_IDEX_Bubble), .EXMEM_Write(s_EXMEM_Write),
      .MEMWB_Bubble(s_MEMWB_Bubble), .Timeout(s_Timeout), .StallCount(s_StallCount)
   );

   // {PC_Write, IFID_Write, IFID_Flush, IDEX_Write, IDEX_Bubble, EXMEM_Write, MEMWB_Bubble}
   logic [6:0] outs;
   assign outs = {PC_Write, IFID_Write, IFID_Flush, IDEX_Write, IDEX_Bubble,
                  EXMEM_Write, MEMWB_Bubble};

   localparam logic [6:0] O_DEF = 7'b1101010;
   localparam logic [6:0] O_LU  = 7'b0001110;
   localparam logic [6:0] O_BR  = 7'b1111110;
   localparam logic [6:0] O_FRZ = 7'b0000001;

   typedef struct {
      logic [2:0] rs, rd, exrd;
      logic       urs, urd, mr, br, req, ack;
      logic [6:0] exp_out;
      logic       exp_stall;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      ID_Rs = 3'd0; ID_Rd = 3'd0; EX_Rd = 3'd0;
      ID_UsesRs = 1'b0; ID_UsesRd = 1'b0; EX_MemRead = 1'b0;
      EX_BranchTaken = 1'b0; MEM_Req = 1'b0; MEM_Ack = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      #1;
   endtask

   function automatic vec_t mk(input logic [2:0] rs, input logic urs, input logic [2:0] rd,
                               input logic urd, input logic [2:0] exrd, input logic mr,
                               input logic br, input logic req, input logic ack,
                               input logic [6:0] eo, input logic es);
      vec_t v;
      v.rs = rs; v.urs = urs; v.rd = rd; v.urd = urd; v.exrd = exrd; v.mr = mr;
      v.br = br; v.req = req; v.ack = ack; v.exp_out = eo; v.exp_stall = es;
      return v;
   endfunction

   initial begin
      int exp_cnt;
      //               rs   urs rd   urd exrd mr br req ack  out    stall
      vecs[0] = mk(3'd0, 0, 3'd0, 0, 3'd0, 0, 0, 0, 0, O_DEF, 0); // idle
      vecs[1] = mk(3'd3, 1, 3'd2, 1, 3'd3, 1, 0, 0, 0, O_LU,  1); // ld r3; add r2,r3
      vecs[2] = mk(3'd3, 1, 3'd2, 1, 3'd3, 0, 0, 0, 0, O_DEF, 0); // load gone to MEM
      vecs[3] = mk(3'd0, 1, 3'd0, 1, 3'd0, 1, 0, 0, 0, O_DEF, 0); // ld r0 never hazards
      vecs[4] = mk(3'd5, 0, 3'd5, 0, 3'd5, 1, 0, 0, 0, O_DEF, 0); // match but no use
      vecs[5] = mk(3'd1, 1, 3'd5, 1, 3'd5, 1, 0, 0, 0, O_LU,  1); // hit on second operand
      vecs[6] = mk(3'd4, 1, 3'd1, 0, 3'd4, 1, 1, 0, 0, O_BR,  0); // branch beats load-use
      vecs[7] = mk(3'd0, 0, 3'd0, 0, 3'd0, 0, 1, 0, 0, O_BR,  0); // branch alone
      vecs[8] = mk(3'd6, 1, 3'd6, 1, 3'd6, 0, 0, 0, 0, O_DEF, 0); // ALU producer forwards
      vecs[9] = mk(3'd0, 0, 3'd0, 0, 3'd0, 0, 0, 1, 1, O_DEF, 0); // single-cycle access

      do_reset();
      chk("reset_outs", 32'(outs), 32'(O_DEF));
      chk("reset_timeout", 32'(Timeout), 32'd0);
      chk("reset_stallcount", 32'(StallCount), 32'd0);

      exp_cnt = 0;
      for (int i = 0; i < 10; i++) begin
         ID_Rs = vecs[i].rs; ID_UsesRs = vecs[i].urs;
         ID_Rd = vecs[i].rd; ID_UsesRd = vecs[i].urd;
         EX_Rd = vecs[i].exrd; EX_MemRead = vecs[i].mr; EX_BranchTaken = vecs[i].br;
         MEM_Req = vecs[i].req; MEM_Ack = vecs[i].ack;
         #1;
         chk($sformatf("vec%0d_outs", i), 32'(outs), 32'(vecs[i].exp_out));
         step();
         if (vecs[i].exp_stall) exp_cnt++;
         chk($sformatf("vec%0d_stallcount", i), 32'(StallCount), 32'(exp_cnt));
      end

      // Memory wait with a branch held in EX: flush only on the ack cycle
      do_reset();
      EX_BranchTaken = 1'b1; MEM_Req = 1'b1; MEM_Ack = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk($sformatf("wait%0d_outs", i), 32'(outs), 32'(O_FRZ));
         step();
      end
      chk("wait_stallcount", 32'(StallCount), 32'd3);
      MEM_Ack = 1'b1;
      #1;
      chk("ack_outs", 32'(outs), 32'(O_BR));
      step();
      chk("ack_stallcount", 32'(StallCount), 32'd3);
      // Second run of three waits must not trip the watchdog if the count cleared
      MEM_Ack = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk($sformatf("rewait%0d_outs", i), 32'(outs), 32'(O_FRZ));
         step();
      end
      chk("rewait_timeout", 32'(Timeout), 32'd0);
      chk("rewait_stallcount", 32'(StallCount), 32'd6);
      MEM_Ack = 1'b1;
      step();
      idle_inputs();
      #1;
      chk("after_wait_outs", 32'(outs), 32'(O_DEF));

      // Watchdog with MEM_TIMEOUT=4
      do_reset();
      MEM_Req = 1'b1; MEM_Ack = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk($sformatf("wd%0d_outs", i), 32'(outs), 32'(O_FRZ));
         chk($sformatf("wd%0d_timeout", i), 32'(Timeout), 32'd0);
         step();
      end
      chk("halted_timeout", 32'(Timeout), 32'd1);
      MEM_Ack = 1'b1;
      #1;
      chk("halted_ack_timeout", 32'(Timeout), 32'd1);
      chk("halted_ack_outs", 32'(outs), 32'(O_FRZ));
      step();
      chk("halted_stallcount", 32'(StallCount), 32'd5);
      do_reset();
      chk("post_halt_timeout", 32'(Timeout), 32'd0);
      chk("post_halt_stallcount", 32'(StallCount), 32'd0);
      chk("post_halt_outs", 32'(outs), 32'(O_DEF));

      // Saturation on the 4-bit counter instance
      do_reset();
      MEM_Req = 1'b1; MEM_Ack = 1'b0;
      repeat (14) step();
      chk("sat_14", 32'(s_StallCount), 32'd14);
      repeat (6) step();
      chk("sat_20", 32'(s_StallCount), 32'd15);
      chk("sat_timeout", 32'(s_Timeout), 32'd0);
      idle_inputs();
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
